traffic_phase_controller: RTL

Master sequencer for the intersection. Steps through the signal phases and drives the per-phase countdown value consumed by the 7-segment countdown decoder. Drives the NS/EW lamp outputs and can optionally service a latched pedestrian request with a dedicated walk phase. Sits between the board clock/reset and the display and lamp drivers.

---
 rtl/traffic_phase_controller.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/traffic_phase_controller.sv
// rtl/traffic_phase_controller.sv - intersection phase sequencer driving countdown, lamps and walk signal
// Optional pedestrian walk phase is built when PED_WALK_EN is defined.
module traffic_phase_controller #(
  parameter int CLK_DIV      = 50000000,
  parameter int GREEN_TIME   = 15,
  parameter int YELLOW_TIME  = 3,
  parameter int ALL_RED_TIME = 1,
  parameter int WALK_TIME    = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ped_req,
  output logic [3:0] count,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic [2:0] phase,
  output logic       phase_start,
  output logic       ped_walk,
  output logic       ped_ack
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [3:0] G_T = 4'(GREEN_TIME);
  localparam logic [3:0] Y_T = 4'(YELLOW_TIME);
  localparam logic [3:0] R_T = 4'(ALL_RED_TIME);
  localparam logic [3:0] W_T = 4'(WALK_TIME);
  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED_A = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALL_RED_B = 3'd5,
    PED_WALK  = 3'd6
  } state_e;

  logic [PW-1:0] presc_q, presc_d;
  state_e        state_q, state_d, next_state;
  logic [3:0]    count_q, count_d;
  logic [2:0]    ns_light_q, ns_light_d, ew_light_q, ew_light_d;
  logic          phase_start_q, phase_start_d;
  logic          tick, legal;

  function automatic logic [3:0] phase_time(input state_e s);
    case (s)
      NS_GREEN, EW_GREEN:   phase_time = G_T;
      NS_YELLOW, EW_YELLOW: phase_time = Y_T;
      ALL_RED_A, ALL_RED_B: phase_time = R_T;
      PED_WALK:             phase_time = W_T;
      default:              phase_time = G_T;
    endcase
  endfunction

  assign tick = (presc_q == PRESC_MAX);

`ifdef PED_WALK_EN
  logic pending_q, pending_d, ped_walk_q, ped_walk_d, ped_ack_q, ped_ack_d, grant;
  assign legal = (state_q != 3'd7);
`else
  logic unused_ped_req;
  assign unused_ped_req = ped_req;
  assign legal = (state_q inside {NS_GREEN, NS_YELLOW, ALL_RED_A, EW_GREEN, EW_YELLOW, ALL_RED_B});
`endif

  always_comb begin
    next_state = NS_GREEN;
    case (state_q)
      NS_GREEN:  next_state = NS_YELLOW;
      NS_YELLOW: next_state = ALL_RED_A;
      ALL_RED_A: next_state = EW_GREEN;
      EW_GREEN:  next_state = EW_YELLOW;
      EW_YELLOW: next_state = ALL_RED_B;
`ifdef PED_WALK_EN
      ALL_RED_B: next_state = pending_q ? PED_WALK : NS_GREEN;
`else
      ALL_RED_B: next_state = NS_GREEN;
`endif
      default:   next_state = NS_GREEN;
    endcase
  end

  always_comb begin
    presc_d       = tick ? '0 : presc_q + 1'b1;
    state_d       = state_q;
    count_d       = count_q;
    phase_start_d = 1'b0;
    // An unreachable encoding is forced back to the start of the cycle.
    if (!legal) begin
      state_d       = NS_GREEN;
      count_d       = G_T;
      phase_start_d = 1'b1;
    end else if (tick) begin
      if (count_q != 4'd0) begin
        count_d = count_q - 4'd1;
      end else begin
        state_d       = next_state;
        count_d       = phase_time(next_state);
        phase_start_d = 1'b1;
      end
    end

    ns_light_d = L_RED;
    ew_light_d = L_RED;
    case (state_d)
      NS_GREEN:  ns_light_d = L_GRN;
      NS_YELLOW: ns_light_d = L_YEL;
      EW_GREEN:  ew_light_d = L_GRN;
      EW_YELLOW: ew_light_d = L_YEL;
      default:   ;
    endcase
  end

`ifdef PED_WALK_EN
  assign grant = tick && legal && (count_q == 4'd0) && (state_q == ALL_RED_B) && pending_q;

  // Clearing on grant beats a request arriving in the same cycle.
  always_comb begin
    pending_d = pending_q;
    if (grant)
      pending_d = 1'b0;
    else if (ped_req && (state_q != PED_WALK))
      pending_d = 1'b1;
    ped_ack_d  = grant;
    ped_walk_d = (state_d == PED_WALK);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q  <= 1'b0;
      ped_walk_q <= 1'b0;
      ped_ack_q  <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      ped_walk_q <= ped_walk_d;
      ped_ack_q  <= ped_ack_d;
    end
  end

  assign ped_walk = ped_walk_q;
  assign ped_ack  = ped_ack_q;
`else
  assign ped_walk = 1'b0;
  assign ped_ack  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q       <= '0;
      state_q       <= NS_GREEN;
      count_q       <= G_T;
      ns_light_q    <= L_GRN;
      ew_light_q    <= L_RED;
      phase_start_q <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      state_q       <= state_d;
      count_q       <= count_d;
      ns_light_q    <= ns_light_d;
      ew_light_q    <= ew_light_d;
      phase_start_q <= phase_start_d;
    end
  end

  assign count       = count_q;
  assign ns_light    = ns_light_q;
  assign ew_light    = ew_light_q;
  assign phase       = state_q;
  assign phase_start = phase_start_q;

endmodule
